// File: rtl/snap_pkg.sv
// Shared widths, the snapshot word layout and a width helper for the
// count snapshot FIFO.
package snap_pkg;

  localparam int COUNT_W   = 8;
  localparam int EPOCH_W_D = 8;

  // One captured logical time value: overflow epoch above the raw count.
  typedef struct packed {
    logic [EPOCH_W_D-1:0] epoch;
    logic [COUNT_W-1:0]   count;
  } snap_t;

  // Width of a snapshot word for a given epoch width.
  function automatic int snap_w(input int epoch_w);
    return epoch_w + COUNT_W;
  endfunction

endpackage

// File: rtl/snap_fifo.sv
// Generic synchronous FIFO. The head entry is read from the storage
// registers, so the output never depends combinationally on push/pop.
module snap_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW-1:0]    wr_q, wr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LW'(DEPTH));
  assign level_o = level_q;
  assign data_o  = mem_q[rd_q];

  // A pop frees a slot in the same cycle, so a push into a full FIFO is
  // accepted when it coincides with a pop.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Next pointer and occupancy values.
  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    level_d = level_q;
    if (do_push) wr_d = wr_q + AW'(1);
    if (do_pop)  rd_d = rd_q + AW'(1);
    if (do_push && !do_pop)      level_d = level_q + LW'(1);
    else if (!do_push && do_pop) level_d = level_q - LW'(1);
  end

  // Storage and pointer registers; clear returns everything to reset state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q    <= '0;
      wr_q    <= '0;
      level_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (clear_i) begin
      rd_q    <= '0;
      wr_q    <= '0;
      level_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      level_q <= level_d;
      if (do_push) mem_q[wr_q] <= data_i;
    end
  end

endmodule

// File: rtl/count_snapshot_fifo.sv
// Extends an 8-bit wrap-around counter with an overflow epoch and queues
// {epoch, count} snapshots on capture requests for a valid/ready consumer.
module count_snapshot_fifo
  import snap_pkg::*;
#(
  parameter int EPOCH_W = 8,
  parameter int DEPTH   = 8,
  parameter int DROP_W  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear_i,
  input  logic [COUNT_W-1:0]         count_i,
  input  logic                       overflow_i,
  input  logic                       capture_i,
  output logic                       snap_valid_o,
  input  logic                       snap_ready_i,
  output logic [EPOCH_W+COUNT_W-1:0] snap_data_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic [DROP_W-1:0]          drop_cnt_o,
  output logic                       epoch_wrapped_o
);

  localparam int SW = snap_w(EPOCH_W);

  logic [EPOCH_W-1:0] epoch_q, epoch_d;
  logic [DROP_W-1:0]  drop_q, drop_d;
  logic               wrapped_q, wrapped_d;
  logic [SW-1:0]      snap_word;
  logic               full, empty, do_pop, push, drop;

  // The counter reads 0 in the same cycle it pulses overflow, so a capture
  // in that cycle must already carry the incremented epoch.
  assign snap_word = {epoch_q + EPOCH_W'(overflow_i), count_i};

  assign snap_valid_o    = ~empty;
  assign do_pop          = snap_ready_i & ~empty;
  assign push            = capture_i & ~clear_i & (~full | do_pop);
  assign drop            = capture_i & ~clear_i & full & ~do_pop;
  assign drop_cnt_o      = drop_q;
  assign epoch_wrapped_o = wrapped_q;

  snap_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (SW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (clear_i),
    .push_i  (push),
    .pop_i   (do_pop),
    .data_i  (snap_word),
    .data_o  (snap_data_o),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level_o)
  );

  // Epoch advance, sticky wrap flag and saturating drop count.
  always_comb begin
    epoch_d   = epoch_q;
    wrapped_d = wrapped_q;
    drop_d    = drop_q;
    if (clear_i) begin
      epoch_d   = '0;
      wrapped_d = 1'b0;
      drop_d    = '0;
    end else begin
      if (overflow_i) begin
        epoch_d = epoch_q + EPOCH_W'(1);
        if (&epoch_q) wrapped_d = 1'b1;
      end
      if (drop && !(&drop_q)) drop_d = drop_q + DROP_W'(1);
    end
  end

  // Top-level state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      epoch_q   <= '0;
      wrapped_q <= 1'b0;
      drop_q    <= '0;
    end else begin
      epoch_q   <= epoch_d;
      wrapped_q <= wrapped_d;
      drop_q    <= drop_d;
    end
  end

endmodule
